// File: rtl/led_ripple_if.sv
// LED ripple control/status bundle: run controls and period reload in, LED drive and step strobe out.
// Ports: en, mode, period_load, period_in (controller -> generator); led, step (generator -> board/display).
// master = controlling side, slave = the pattern generator.
interface led_ripple_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic [1:0]       mode;
  logic             period_load;
  logic [CNT_W-1:0] period_in;
  logic [WIDTH-1:0] led;
  logic             step;

  modport master (
    output en, mode, period_load, period_in,
    input  led, step
  );

  modport slave (
    input  en, mode, period_load, period_in,
    output led, step
  );
endinterface

// File: rtl/led_ripple_ctrl.sv
// Parametrised LED pattern generator: rotate left/right, bounce and fill bar, advancing every `period` cycles.
// Ports: clk, rst_n (sync, active low), bus (slave: en, mode, period_load, period_in in; led, step out).
// led and step are registered; step pulses in the cycle a new led value first appears.
module led_ripple_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SHIFT_TIME = 5,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  led_ripple_if.slave   bus
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(SHIFT_TIME);
  localparam logic [WIDTH-1:0] LED_INIT   = WIDTH'(1);

  logic [1:0]       mode_q,   mode_n;
  logic [CNT_W-1:0] cnt,      cnt_n;
  logic [CNT_W-1:0] period,   period_n;
  logic [WIDTH-1:0] led_q,    led_n;
  logic             step_q,   step_n;
  dir_t             dir,      dir_n;

  // Pattern advance candidates (only committed on a step edge)
  logic [WIDTH-1:0] adv_led;
  dir_t             adv_dir;

  // A step only happens when mode == mode_q, so mode_q selects the pattern.
  always_comb begin
    adv_led = led_q;
    adv_dir = dir;
    case (mode_q)
      2'b00: adv_led = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      2'b01: adv_led = {led_q[0], led_q[WIDTH-1:1]};
      2'b10: begin
        if (dir == DIR_LEFT) adv_led = led_q << 1;
        else                 adv_led = led_q >> 1;
        // Turn around on the step that lands on an end, so ends are not revisited.
        if (adv_led[WIDTH-1])  adv_dir = DIR_RIGHT;
        else if (adv_led[0])   adv_dir = DIR_LEFT;
      end
      default: begin
        // Shifting ones in also takes all-zeros to 0001; only all-ones needs a special case.
        if (&led_q) adv_led = '0;
        else        adv_led = {led_q[WIDTH-2:0], 1'b1};
      end
    endcase
  end

  // Next-state with priority: mode change > period load > step > idle.
  always_comb begin
    mode_n   = mode_q;
    cnt_n    = cnt;
    period_n = period;
    led_n    = led_q;
    step_n   = 1'b0;
    dir_n    = dir;

    if (bus.mode != mode_q) begin
      mode_n = bus.mode;
      led_n  = LED_INIT;
      cnt_n  = '0;
      dir_n  = DIR_LEFT;
    end else if (bus.period_load) begin
      period_n = (bus.period_in == '0) ? ONE : bus.period_in;
      cnt_n    = '0;
    end else if (bus.en) begin
      // cnt is cleared on every load, so it never passes period-1 and never wraps.
      if (cnt == period - ONE) begin
        cnt_n  = '0;
        led_n  = adv_led;
        dir_n  = adv_dir;
        step_n = 1'b1;
      end else begin
        cnt_n = cnt + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 2'b00;
      cnt    <= '0;
      period <= RST_PERIOD;
      led_q  <= LED_INIT;
      step_q <= 1'b0;
      dir    <= DIR_LEFT;
    end else begin
      mode_q <= mode_n;
      cnt    <= cnt_n;
      period <= period_n;
      led_q  <= led_n;
      step_q <= step_n;
      dir    <= dir_n;
    end
  end

  assign bus.led  = led_q;
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_ripple_ctrl.sv
// Scoreboard bench for led_ripple_ctrl: two instances (8 LEDs/period 5, 4 LEDs/period 2) share one stimulus stream.
// Expected led/step come from a step-count model (pattern as a function of steps taken since reset/mode change).
// Expectations are queued at each active edge and checked by a separate monitor on the falling edge.
module tb_led_ripple_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_ripple_if #(.WIDTH(8), .CNT_W(16)) if8 ();
  led_ripple_if #(.WIDTH(4), .CNT_W(16)) if4 ();

  led_ripple_ctrl #(.WIDTH(8), .SHIFT_TIME(5), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
  );
  led_ripple_ctrl #(.WIDTH(4), .SHIFT_TIME(2), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );

  typedef struct packed {
    logic [31:0] led0;
    logic        st0;
    logic [31:0] led1;
    logic        st1;
  } exp_t;

  exp_t sbq[$];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state per instance
  int w_of[2]  = '{8, 4};
  int rst_p[2] = '{5, 2};
  int k[2];      // steps taken since last reset / mode change
  int cnt[2];
  int per[2];
  int mq[2];
  bit st[2];

  function automatic logic [31:0] pattern(input int m, input int steps, input int w);
    logic [63:0] one;
    int p, pos;
    one = 64'd1;
    case (m)
      0: begin
        p = steps % w;
        pattern = 32'(one << p);
      end
      1: begin
        p = (w - (steps % w)) % w;
        pattern = 32'(one << p);
      end
      2: begin
        p   = steps % (2 * w - 2);
        pos = (p < w) ? p : (2 * w - 2 - p);
        pattern = 32'(one << pos);
      end
      default: begin
        p = steps % (w + 1);
        pattern = (p == w) ? 32'd0 : 32'((one << (p + 1)) - 64'd1);
      end
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [1:0] m,
                            input logic l, input logic [15:0] p);
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0;
      if (!r) begin
        k[d] = 0; cnt[d] = 0; per[d] = rst_p[d]; mq[d] = 0;
      end else if (int'(m) != mq[d]) begin
        mq[d] = int'(m); k[d] = 0; cnt[d] = 0;
      end else if (l) begin
        per[d] = (p == 16'd0) ? 1 : int'(p);
        cnt[d] = 0;
      end else if (e) begin
        if (cnt[d] == per[d] - 1) begin
          cnt[d] = 0; k[d] = k[d] + 1; st[d] = 1'b1;
        end else begin
          cnt[d] = cnt[d] + 1;
        end
      end
    end
  endtask

  // One clock of stimulus: drive away from the edge, update the model on the edge, queue the expectation.
  task automatic apply(input logic r, input logic e, input logic [1:0] m,
                       input logic l, input logic [15:0] p);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    if8.en = e; if8.mode = m; if8.period_load = l; if8.period_in = p;
    if4.en = e; if4.mode = m; if4.period_load = l; if4.period_in = p;
    @(posedge clk);
    model_edge(r, e, m, l, p);
    x.led0 = pattern(mq[0], k[0], w_of[0]);
    x.st0  = st[0];
    x.led1 = pattern(mq[1], k[1], w_of[1]);
    x.st1  = st[1];
    sbq.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh led/step every cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      check("led8",  {24'd0, if8.led},  x.led0);
      check("step8", {31'd0, if8.step}, {31'd0, x.st0});
      check("led4",  {28'd0, if4.led},  x.led1);
      check("step4", {31'd0, if4.step}, {31'd0, x.st1});
    end
  end

  initial begin
    rst_n = 1'b0;
    if8.en = 1'b0; if8.mode = 2'b00; if8.period_load = 1'b0; if8.period_in = '0;
    if4.en = 1'b0; if4.mode = 2'b00; if4.period_load = 1'b0; if4.period_in = '0;

    // Reset then default rotate left
    repeat (2)  apply(1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    repeat (45) apply(1'b1, 1'b1, 2'd0, 1'b0, 16'd0);

    // Rotate right from reset, then bounce through more than a full cycle
    apply(1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
    repeat (12) apply(1'b1, 1'b1, 2'd1, 1'b0, 16'd0);
    repeat (80) apply(1'b1, 1'b1, 2'd2, 1'b0, 16'd0);

    // Mode change together with a load: load must be dropped
    apply(1'b1, 1'b1, 2'd3, 1'b1, 16'd1);
    repeat (12) apply(1'b1, 1'b1, 2'd3, 1'b0, 16'd0);
    // Fill bar at period 2
    apply(1'b1, 1'b1, 2'd3, 1'b1, 16'd2);
    repeat (25) apply(1'b1, 1'b1, 2'd3, 1'b0, 16'd0);

    // Reload period 3 while cnt=2
    apply(1'b1, 1'b1, 2'd3, 1'b1, 16'd3);
    repeat (2) apply(1'b1, 1'b1, 2'd3, 1'b0, 16'd0);
    apply(1'b1, 1'b1, 2'd3, 1'b1, 16'd3);
    repeat (8) apply(1'b1, 1'b1, 2'd3, 1'b0, 16'd0);

    // Period 0 behaves as 1
    apply(1'b1, 1'b1, 2'd3, 1'b1, 16'd0);
    repeat (10) apply(1'b1, 1'b1, 2'd3, 1'b0, 16'd0);

    // Enable freeze at cnt=3 with period 5
    apply(1'b1, 1'b1, 2'd0, 1'b0, 16'd0);
    apply(1'b1, 1'b1, 2'd0, 1'b1, 16'd5);
    repeat (3)  apply(1'b1, 1'b1, 2'd0, 1'b0, 16'd0);
    repeat (10) apply(1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
    repeat (6)  apply(1'b1, 1'b1, 2'd0, 1'b0, 16'd0);

    // Reset together with load and mode change
    apply(1'b0, 1'b1, 2'd2, 1'b1, 16'd7);
    repeat (12) apply(1'b1, 1'b1, 2'd0, 1'b0, 16'd0);

    // Randomised traffic
    begin
      logic [1:0] cur_mode;
      cur_mode = 2'd0;
      for (int i = 0; i < 2000; i++) begin
        logic r, e, l;
        logic [15:0] p;
        r = ($urandom_range(0, 199) != 0);
        e = ($urandom_range(0, 9) < 8);
        l = ($urandom_range(0, 29) == 0);
        p = 16'($urandom_range(0, 7));
        if ($urandom_range(0, 49) == 0) cur_mode = 2'($urandom_range(0, 3));
        apply(r, e, cur_mode, l, p);
      end
    end

    @(negedge clk);
    #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_ripple_ctrl.md
Name: led_ripple_ctrl

Overview:
Parametrised LED pattern generator, successor to the fixed 8-bit rippling LED. Drives a WIDTH-bit LED bank, advancing the pattern once every `period` clock cycles. Supports four run-time modes (rotate left, rotate right, bounce, fill bar), an enable, and a run-time reloadable step period. Sits at board top level between the clock and the LED pins; also exports a step strobe for other display logic.

Parameters:
WIDTH, 8, number of LEDs; legal range 2..32.
SHIFT_TIME, 5, reset value of the step period in clk cycles; legal range 1..2^CNT_W-1.
CNT_W, 16, width of the period register, the period counter and period_in.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous active-low reset.
en  input  1  1 = pattern runs; 0 = counter and pattern frozen.
mode  input  2  00 rotate left, 01 rotate right, 10 bounce, 11 fill bar.
period_load  input  1  1-cycle strobe; loads period_in into the period register.
period_in  input  CNT_W  new step period in cycles; 0 is treated as 1.
led  output  WIDTH  LED drive, registered.
step  output  1  registered; high for exactly the one cycle in which a new led value first appears.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0: led = 1 (bit0 only), cnt = 0, period = SHIFT_TIME, dir = left, mode_q = 00, step = 0. Reset overrides every other input, including mid-step and mid-load.
- Registered mode_q follows mode. A mismatch mode != mode_q is a mode change, detected on the next edge.
- Per-edge priority: reset > mode change > period_load > step > idle.
- Mode change: mode_q <= mode, led <= 1, cnt <= 0, dir <= left, step <= 0. This applies regardless of en.
- period_load: period <= (period_in == 0 ? 1 : period_in), cnt <= 0, no step this edge. led is unchanged.
- Counting: when en=1, cnt increments each edge. When en=1 and cnt == period-1, a step occurs: cnt <= 0, led <= next(led), step <= 1. Otherwise step <= 0.
- Step cadence: the first step after reset or a reload is visible after exactly `period` edges with en=1.
- Period shrink via load: because the load clears cnt, cnt never exceeds period-1.
- en=0: cnt, led and dir hold; step <= 0. Counting resumes from the held cnt.
- next(led) per mode:
  - 00: rotate left; the MSB wraps to bit0.
  - 01: rotate right; bit0 wraps to the MSB.
  - 10: one-hot moves in direction dir. When a step lands on bit WIDTH-1, dir <= right; when it lands on bit0, dir <= left. Ends have no dwell and no double visit. Cycle length is 2*WIDTH-2 steps. WIDTH=4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - 11: led <= {led[WIDTH-2:0], 1'b1}, except all-ones goes to all-zeros and all-zeros goes to 0001. Cycle length is WIDTH+1 steps.
- Arithmetic: cnt compare is unsigned CNT_W-bit. No wrap of cnt is possible because cnt is cleared at period-1.
- period=1: a step occurs on every enabled edge and step stays high continuously.

Test Plan:
- Reset and default rotate: WIDTH=8, SHIFT_TIME=5, rst_n=0 for 2 edges, then en=1, mode=00 -> led=00000001 at release; led=00000010 after 5th edge with step=1 for 1 cycle; 10000000 after 35 edges, 00000001 after 40.
- Rotate right and bounce: mode=01 from reset -> led 00000001 then 10000000 after 5 edges. Change to mode=10 -> led forced 00000001 next edge, then 00000010, ..., 10000000, 01000000, ..., 00000001, 00000010, each 5 cycles apart; led never shows 10000000 twice consecutively.
- Fill bar, WIDTH=4, period 2: mode=11 -> 0001, 0011, 0111, 1111, 0000, 0001 every 2 cycles.
- Period reload and zero: period_in=3 with period_load pulsed while cnt=2 -> cnt cleared, no step that edge, next step 3 edges later. period_in=0 -> step high every enabled cycle, led advances each edge.
- Enable freeze: en=0 at cnt=3 for 10 cycles -> led constant, step=0. en=1 -> step after 2 more edges (cnt 3→4).
- Simultaneous events: mode change and period_load on the same edge -> mode effect applied (led=1, cnt=0) and period unchanged. rst_n=0 together with period_load and mode change -> full reset values, period=SHIFT_TIME.
